gin_multicast: RTL
==================

# gin_multicast

Global input network (GIN) for one operand stream (ifmap, filter or ipsum) of the PE array. It is the receiving end of the controller's `*_enable` / `*_ready` handshake and of its `set_row` / `set_id` scan-chain writes. Each accepted word carries a `(row_id, col_id)` tag and is multicast to every PE whose scan-configured X-bus row tag and PE id both match. The block returns `ready` to the controller only after all targeted PEs have taken the word.

## Interface
Parameters:
- `XBUS_NUMS`, 12, number of X-buses (PE rows).
- `PE_NUMS`, 14, PEs per X-bus.
- `ROW_LEN`, 4, width of the row tag.
- `ID_LEN`, 4, width of the PE id tag.
- `DATA_WIDTH`, 32, width of the payload.

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `set_row`  in  1  shift `scan_in[ROW_LEN-1:0]` into the row-tag chain.
- `set_id`  in  1  shift `scan_in[ID_LEN-1:0]` into the id-tag chain.
- `scan_in`  in  DATA_WIDTH  scan-chain word; only the low bits are used.
- `enable`  in  1  controller word valid.
- `ready`  out  1  block can accept a word.
- `row_id`  in  ROW_LEN  destination row tag.
- `col_id`  in  ID_LEN  destination PE id tag.
- `data_in`  in  DATA_WIDTH  payload.
- `pe_valid`  out  XBUS_NUMS*PE_NUMS  per-PE valid; bit index is `x*PE_NUMS+p`.
- `pe_ready`  in  XBUS_NUMS*PE_NUMS  per-PE ready.
- `pe_data`  out  DATA_WIDTH  payload broadcast to all PEs.
- `no_target`  out  1  one-cycle pulse when an accepted word matched no PE.

## Operation
Tag storage:
- `row_tag[x]`, with XBUS_NUMS entries.
- `id_tag[x][p]`, with XBUS_NUMS*PE_NUMS entries.
- All tags reset to 0.

Scan-chain shifts:
- `set_row` high: `row_tag[XBUS_NUMS-1]` <= `scan_in`, and `row_tag[i]` <= `row_tag[i+1]`. After XBUS_NUMS shifts, the first word written sits in `row_tag[0]`.
- `set_id`: same scheme over the flat index `x*PE_NUMS+p`.
- Both asserted in the same cycle: both chains shift.
- Shifts are legal in any state. They never alter a word already in flight, because the target mask is frozen at accept.

State machine `S_IDLE`, `S_DELIVER`:
- **S_IDLE:** `ready`=1. On `enable && ready`:
  - Latch `data_in` into `pe_data`.
  - Compute `mask[x*PE_NUMS+p] = (row_tag[x]==row_id) && (id_tag[x][p]==col_id)`.
  - Clear `done`.
  - If `mask` is nonzero, go to S_DELIVER.
  - If `mask` is zero, stay in S_IDLE and pulse `no_target` next cycle. The word is dropped.
- **S_DELIVER:** `ready`=0, `pe_valid = mask & ~done`.
  - Each cycle, `done |= pe_valid & pe_ready`.
  - When `(done | (pe_valid & pe_ready)) == mask`, return to S_IDLE.
  - PEs may accept in any order, in any cycles, independently.
- `pe_valid` for a PE stays high until that PE has accepted. Once it has accepted, it never reasserts for the same word.
- `pe_data` is stable throughout S_DELIVER.

## Timing
- Reset values:
  - state = S_IDLE
  - `ready`=1, `pe_valid`=0, `pe_data`=0, `no_target`=0
  - mask=0, done=0
- `ready` and `pe_valid` are decoded from registered state. There is no combinational path from `enable` to `ready`. `pe_valid` depends only on registers.
- Word accepted on edge N: `pe_valid` rises in cycle N+1.
- If all targets are ready in cycle N+1, `ready` returns high in cycle N+2. Peak rate is one delivered word per 2 cycles.
- A zero-match word leaves `ready` high, so back-to-back accepts proceed at one per cycle. `no_target` is high in cycle N+1.
- Reset asserted mid-delivery: immediate return to S_IDLE. The in-flight word and all tags are lost, and `pe_valid` drops asynchronously.

## Configuration
`GIN_BROADCAST_EN`:
- Defined: an all-ones `row_id` matches every row, and an all-ones `col_id` matches every PE id in a matching row. This is wildcard multicast.
- Not defined: all-ones is an ordinary tag value compared literally.

## Structure
- Shared package `gin_pkg`:
  - state encoding (`S_IDLE`, `S_DELIVER`)
  - default parameter constants `XBUS_NUMS`, `PE_NUMS`, `ROW_LEN`, `ID_LEN`
  - the wildcard constant used under `GIN_BROADCAST_EN`
- One sub-module `gin_tag_match`: combinational, taking `row_tag`, `id_tag`, `row_id`, `col_id` and producing `mask`. It is instantiated once and holds the wildcard logic.
- Scan chains, FSM and done-tracking live in `gin_multicast`.

## Test plan
- **Scan config:** shift rows 0..11 and ids `p` for every row, then send tag (3,5) with `data_in`=0xA5A5 and all `pe_ready`=1.
  - Only bit 3*14+5=47 of `pe_valid` pulses, for one cycle.
  - `pe_data`=0xA5A5.
  - `ready` is low for exactly one cycle.
- **Multi-target, staggered acceptance:** configure ids=0 in rows 2 and 4, send (row tag 2, id 0) ... also set `row_tag[4]`=2, so both bit 28 and bit 56 are targets.
  - Raise `pe_ready[28]` at N+1 and `pe_ready[56]` at N+3.
  - bit 28 drops after N+1, bit 56 is held until N+3.
  - `ready` returns at N+4.
- **No match:** send (15,15) with no matching tags.
  - `no_target`=1 in cycle N+1.
  - `pe_valid` stays 0 and `ready` stays 1.
  - A second word is accepted at N+1.
- **Shift during delivery:** shift `set_id` while in S_DELIVER with the target's `pe_ready`=0.
  - `pe_valid` mask is unchanged until the target accepts.
- **Reset mid-delivery:** assert `rst`=0 while `pe_valid`≠0.
  - `pe_valid`=0 immediately, `ready`=1 after release, and all tags are 0.
- **`GIN_BROADCAST_EN` defined:** send (15,15) with all `pe_ready`=1.
  - All 168 `pe_valid` bits are high in N+1.
  - Without the macro, the same stimulus gives `no_target`.

Source files
------------

// File: rtl/gin_pkg.sv
// gin_pkg
// Shared definitions for the global input network (GIN) multicast block:
//   - gin_state_e          : delivery FSM state encoding (S_IDLE, S_DELIVER)
//   - DEFAULT_XBUS_NUMS    : default number of X-buses (PE rows)
//   - DEFAULT_PE_NUMS      : default number of PEs per X-bus
//   - DEFAULT_ROW_LEN      : default width of the row tag
//   - DEFAULT_ID_LEN       : default width of the PE id tag
//   - GIN_WILDCARD         : all-ones tag, truncated to the tag width where used;
//                            only acts as a wildcard when GIN_BROADCAST_EN is defined
package gin_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_DELIVER = 1'b1
  } gin_state_e;

  localparam int DEFAULT_XBUS_NUMS = 12;
  localparam int DEFAULT_PE_NUMS   = 14;
  localparam int DEFAULT_ROW_LEN   = 4;
  localparam int DEFAULT_ID_LEN    = 4;

  localparam logic [31:0] GIN_WILDCARD = 32'hFFFF_FFFF;

endpackage

// File: rtl/gin_tag_match.sv
// gin_tag_match
// Combinational tag matcher. A PE is targeted when its X-bus row tag equals
// row_id and its own id tag equals col_id.
// Optional feature macro: GIN_BROADCAST_EN. When defined, an all-ones row_id
// matches every row and an all-ones col_id matches every PE id within a
// matching row. When undefined, all-ones is compared literally.
// Ports:
//   row_tag  in  XBUS_NUMS x ROW_LEN          per-row tag (index x)
//   id_tag   in  XBUS_NUMS*PE_NUMS x ID_LEN   per-PE id tag (index x*PE_NUMS+p)
//   row_id   in  ROW_LEN                      destination row tag
//   col_id   in  ID_LEN                       destination PE id tag
//   mask     out XBUS_NUMS*PE_NUMS            one bit per targeted PE
module gin_tag_match
  import gin_pkg::*;
#(
  parameter int XBUS_NUMS = DEFAULT_XBUS_NUMS,
  parameter int PE_NUMS   = DEFAULT_PE_NUMS,
  parameter int ROW_LEN   = DEFAULT_ROW_LEN,
  parameter int ID_LEN    = DEFAULT_ID_LEN
) (
  input  logic [XBUS_NUMS-1:0][ROW_LEN-1:0]       row_tag,
  input  logic [XBUS_NUMS*PE_NUMS-1:0][ID_LEN-1:0] id_tag,
  input  logic [ROW_LEN-1:0]                      row_id,
  input  logic [ID_LEN-1:0]                       col_id,
  output logic [XBUS_NUMS*PE_NUMS-1:0]            mask
);

  logic row_any;
  logic col_any;

`ifdef GIN_BROADCAST_EN
  localparam logic [ROW_LEN-1:0] ROW_WILD = ROW_LEN'(GIN_WILDCARD);
  localparam logic [ID_LEN-1:0]  ID_WILD  = ID_LEN'(GIN_WILDCARD);

  assign row_any = (row_id == ROW_WILD);
  assign col_any = (col_id == ID_WILD);
`else
  assign row_any = 1'b0;
  assign col_any = 1'b0;
`endif

  always_comb begin
    mask = '0;
    for (int x = 0; x < XBUS_NUMS; x++) begin
      for (int p = 0; p < PE_NUMS; p++) begin
        mask[x*PE_NUMS+p] = (row_any || (row_tag[x] == row_id)) &&
                            (col_any || (id_tag[x*PE_NUMS+p] == col_id));
      end
    end
  end

endmodule

// File: rtl/gin_multicast.sv
// gin_multicast
// Global input network for one operand stream of the PE array. Accepts tagged
// words from the controller and multicasts each one to every PE whose scan-
// configured row tag and id tag match; ready returns only after every
// targeted PE has taken the word. A word matching no PE is dropped and
// reported with a one-cycle no_target pulse.
// Optional feature macro: GIN_BROADCAST_EN (wildcard all-ones tags, handled
// inside gin_tag_match).
// Ports:
//   clk        in  1                  clock
//   rst        in  1                  asynchronous active-low reset
//   set_row    in  1                  shift scan_in low bits into the row-tag chain
//   set_id     in  1                  shift scan_in low bits into the id-tag chain
//   scan_in    in  DATA_WIDTH         scan word (only low tag bits used)
//   enable     in  1                  controller word valid
//   ready      out 1                  block can accept a word
//   row_id     in  ROW_LEN            destination row tag
//   col_id     in  ID_LEN             destination PE id tag
//   data_in    in  DATA_WIDTH         payload
//   pe_valid   out XBUS_NUMS*PE_NUMS  per-PE valid, bit x*PE_NUMS+p
//   pe_ready   in  XBUS_NUMS*PE_NUMS  per-PE ready
//   pe_data    out DATA_WIDTH         payload broadcast to all PEs
//   no_target  out 1                  pulse: accepted word matched no PE
module gin_multicast
  import gin_pkg::*;
#(
  parameter int XBUS_NUMS  = DEFAULT_XBUS_NUMS,
  parameter int PE_NUMS    = DEFAULT_PE_NUMS,
  parameter int ROW_LEN    = DEFAULT_ROW_LEN,
  parameter int ID_LEN     = DEFAULT_ID_LEN,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_row,
  input  logic                         set_id,
  input  logic [DATA_WIDTH-1:0]        scan_in,
  input  logic                         enable,
  output logic                         ready,
  input  logic [ROW_LEN-1:0]           row_id,
  input  logic [ID_LEN-1:0]            col_id,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [XBUS_NUMS*PE_NUMS-1:0] pe_valid,
  input  logic [XBUS_NUMS*PE_NUMS-1:0] pe_ready,
  output logic [DATA_WIDTH-1:0]        pe_data,
  output logic                         no_target
);

  localparam int NUM_PE = XBUS_NUMS * PE_NUMS;

  gin_state_e state_q, state_d;

  logic [XBUS_NUMS-1:0][ROW_LEN-1:0] row_tag_q, row_tag_d;
  logic [NUM_PE-1:0][ID_LEN-1:0]     id_tag_q, id_tag_d;

  logic [NUM_PE-1:0]     mask_q, mask_d;
  logic [NUM_PE-1:0]     done_q, done_d;
  logic [DATA_WIDTH-1:0] pe_data_q, pe_data_d;
  logic                  no_target_q, no_target_d;

  logic [NUM_PE-1:0] match_mask;
  logic [NUM_PE-1:0] accepted;

  // Only the low tag bits of the scan word are stored.
  logic unused_scan_bits;
  assign unused_scan_bits = ^scan_in;

  gin_tag_match #(
    .XBUS_NUMS (XBUS_NUMS),
    .PE_NUMS   (PE_NUMS),
    .ROW_LEN   (ROW_LEN),
    .ID_LEN    (ID_LEN)
  ) u_tag_match (
    .row_tag (row_tag_q),
    .id_tag  (id_tag_q),
    .row_id  (row_id),
    .col_id  (col_id),
    .mask    (match_mask)
  );

  // Both outputs come straight from registers, so enable never reaches ready
  // combinationally.
  assign ready     = (state_q == S_IDLE);
  assign pe_valid  = (state_q == S_DELIVER) ? (mask_q & ~done_q) : '0;
  assign pe_data   = pe_data_q;
  assign no_target = no_target_q;

  // Scan chains: new word enters at the top entry, everything moves down one,
  // so the first word written ends up in entry 0 after a full chain of shifts.
  always_comb begin
    row_tag_d = row_tag_q;
    id_tag_d  = id_tag_q;
    if (set_row) begin
      row_tag_d = {scan_in[ROW_LEN-1:0], row_tag_q[XBUS_NUMS-1:1]};
    end
    if (set_id) begin
      id_tag_d = {scan_in[ID_LEN-1:0], id_tag_q[NUM_PE-1:1]};
    end
  end

  // Delivery FSM. The target mask is frozen at accept so later scan shifts
  // cannot redirect a word already in flight.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    done_d      = done_q;
    pe_data_d   = pe_data_q;
    no_target_d = 1'b0;
    accepted    = pe_valid & pe_ready;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          pe_data_d = data_in;
          mask_d    = match_mask;
          done_d    = '0;
          if (|match_mask) begin
            state_d = S_DELIVER;
          end else begin
            no_target_d = 1'b1;
          end
        end
      end
      S_DELIVER: begin
        done_d = done_q | accepted;
        if (done_d == mask_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      row_tag_q   <= '0;
      id_tag_q    <= '0;
      mask_q      <= '0;
      done_q      <= '0;
      pe_data_q   <= '0;
      no_target_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_tag_q   <= row_tag_d;
      id_tag_q    <= id_tag_d;
      mask_q      <= mask_d;
      done_q      <= done_d;
      pe_data_q   <= pe_data_d;
      no_target_q <= no_target_d;
    end
  end

endmodule
